// File: rtl/pifo_rank_queue_if.sv
// Push/pop handshake bundle linking the DRR rank stage, the PIFO queue and the scheduler.
interface pifo_rank_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_req;
  logic                  pop_valid;
  logic [DATA_WIDTH-1:0] pop_data;

  modport master (output push_valid, push_data, pop_req, input pop_valid, pop_data);
  modport slave  (input push_valid, push_data, pop_req, output pop_valid, pop_data);
endinterface

// File: rtl/pifo_rank_queue.sv
// Sorted push-in-first-out queue of rank tuples; head (slot 0) always holds the smallest key.
// Optional macro PIFO_TAIL_EVICT_EN: a push into a full queue evicts the tail when its key is smaller.
module pifo_rank_queue #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int KEY_LSB    = 12,
  parameter int KEY_WIDTH  = 19,
  parameter int CNT_WIDTH  = 16,
  localparam int OCC_W     = $clog2(DEPTH) + 1
) (
  input  logic                  clk_dp,
  input  logic                  rst,
  pifo_rank_queue_if.slave      bus,
  output logic [DATA_WIDTH-1:0] last_pkt_info,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  drop_cnt
);

  logic [DATA_WIDTH-1:0] data_q   [DEPTH];
  logic [DATA_WIDTH-1:0] sh_data  [DEPTH];
  logic [DATA_WIDTH-1:0] nxt_data [DEPTH];
  logic [DEPTH-1:0]      valid_q;
  logic [DEPTH-1:0]      sh_valid;
  logic [DEPTH-1:0]      nxt_valid;
  logic [DEPTH-1:0]      le;
  logic [KEY_WIDTH-1:0]  new_key;
  logic                  do_pop;
  logic                  blocked;
  logic                  evict;
  logic                  ins;
  logic                  grow;
  logic [OCC_W-1:0]      occ_next;

  function automatic logic [KEY_WIDTH-1:0] key_of(input logic [DATA_WIDTH-1:0] d);
    return d[KEY_LSB +: KEY_WIDTH];
  endfunction

  assign do_pop  = bus.pop_req && !empty;
  assign new_key = key_of(bus.push_data);
  assign blocked = bus.push_valid && full && !do_pop;

`ifdef PIFO_TAIL_EVICT_EN
  assign evict = blocked && (new_key < key_of(data_q[DEPTH-1]));
`else
  assign evict = 1'b0;
`endif

  assign ins  = (bus.push_valid && !blocked) || evict;
  assign grow = ins && !evict;

  // Pop happens first, so the insert position is found among the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH-1; i++) begin
      sh_data[i]  = do_pop ? data_q[i+1]  : data_q[i];
      sh_valid[i] = do_pop ? valid_q[i+1] : valid_q[i];
    end
    sh_data[DEPTH-1]  = do_pop ? '0   : data_q[DEPTH-1];
    sh_valid[DEPTH-1] = do_pop ? 1'b0 : valid_q[DEPTH-1];
  end

  // le is a prefix mask (contents are sorted); the new tuple lands just past it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      le[i] = sh_valid[i] && (key_of(sh_data[i]) <= new_key);
    end
    nxt_data  = sh_data;
    nxt_valid = sh_valid;
    if (ins) begin
      if (!le[0]) begin
        nxt_data[0]  = bus.push_data;
        nxt_valid[0] = 1'b1;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (!le[i]) begin
          nxt_data[i]  = le[i-1] ? bus.push_data : sh_data[i-1];
          nxt_valid[i] = le[i-1] | sh_valid[i-1];
        end
      end
    end
  end

  always_comb begin
    occ_next = occupancy;
    if (do_pop && !grow) begin
      occ_next = occupancy - OCC_W'(1);
    end else if (grow && !do_pop) begin
      occ_next = occupancy + OCC_W'(1);
    end
  end

  always_ff @(posedge clk_dp or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q       <= '0;
      occupancy     <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      bus.pop_valid <= 1'b0;
      bus.pop_data  <= '0;
      last_pkt_info <= '0;
      drop_cnt      <= '0;
    end else begin
      data_q        <= nxt_data;
      valid_q       <= nxt_valid;
      occupancy     <= occ_next;
      full          <= (occ_next == OCC_W'(DEPTH));
      empty         <= (occ_next == '0);
      bus.pop_valid <= do_pop;
      if (do_pop) begin
        bus.pop_data  <= data_q[0];
        last_pkt_info <= data_q[0];
      end
      if (blocked && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pifo_rank_queue.sv
// Self-checking bench for pifo_rank_queue: directed scenarios plus random traffic against a queue model.
module tb_pifo_rank_queue;

  localparam int DEPTH = 16;
  localparam int DW    = 32;

  logic          clk_dp = 1'b0;
  logic          rst;
  logic [DW-1:0] last_pkt_info;
  logic [4:0]    occupancy;
  logic          full;
  logic          empty;
  logic [15:0]   drop_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mq [$];
  logic          exp_pv;
  logic [DW-1:0] exp_pd;
  logic [DW-1:0] exp_last;
  int            exp_drop;

  pifo_rank_queue_if #(.DATA_WIDTH(DW)) bus ();

  pifo_rank_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .KEY_LSB(12), .KEY_WIDTH(19), .CNT_WIDTH(16)
  ) dut (
    .clk_dp(clk_dp),
    .rst(rst),
    .bus(bus),
    .last_pkt_info(last_pkt_info),
    .occupancy(occupancy),
    .full(full),
    .empty(empty),
    .drop_cnt(drop_cnt)
  );

  always #5 clk_dp = ~clk_dp;

  function automatic int key_of(input logic [DW-1:0] d);
    return int'(d[30:12]);
  endfunction

  function automatic logic [DW-1:0] mk(input int k, input int info);
    logic [DW-1:0] t;
    t        = '0;
    t[30:12] = 19'(k);
    t[11:0]  = 12'(info);
    return t;
  endfunction

  // Reference: pop the front, then insert after every entry whose key is <= the new key.
  task automatic model_step(input logic pv, input logic [DW-1:0] pd, input logic pr);
    int pos;
    exp_pv = pr && (mq.size() > 0);
    if (exp_pv) begin
      exp_pd   = mq.pop_front();
      exp_last = exp_pd;
    end
    if (pv) begin
      if (mq.size() == DEPTH) begin
        if (exp_drop < 65535) exp_drop++;
`ifdef PIFO_TAIL_EVICT_EN
        if (key_of(pd) < key_of(mq[$])) void'(mq.pop_back());
`endif
      end
      if (mq.size() < DEPTH) begin
        pos = 0;
        foreach (mq[i]) if (key_of(mq[i]) <= key_of(pd)) pos++;
        mq.insert(pos, pd);
      end
    end
  endtask

  task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pr);
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_req    = pr;
    model_step(pv, pd, pr);
    @(posedge clk_dp);
    #1;
    bus.push_valid = 1'b0;
    bus.pop_req    = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_req    = 1'b0;
    mq.delete();
    exp_pv   = 1'b0;
    exp_pd   = '0;
    exp_last = '0;
    exp_drop = 0;
    @(negedge clk_dp);
    @(negedge clk_dp);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({occupancy, empty, full, bus.pop_valid, bus.pop_data, last_pkt_info, drop_cnt}
        !== {5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0}) begin
      failures++;
      $display("[TB] FAIL reset_state: got occ=%0d empty=%b full=%b pv=%b pd=%h last=%h drop=%0d required 0/1/0/0/0/0/0",
               occupancy, empty, full, bus.pop_valid, bus.pop_data, last_pkt_info, drop_cnt);
    end
  endtask

  task automatic test_sorted_order();
    int wk [4] = '{2, 2, 5, 9};
    int wi [4] = '{2, 4, 1, 3};
    do_reset();
    cycle(1'b1, mk(5, 1), 1'b0);
    cycle(1'b1, mk(2, 2), 1'b0);
    cycle(1'b1, mk(9, 3), 1'b0);
    cycle(1'b1, mk(2, 4), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== mk(wk[i], wi[i])) begin
        failures++;
        $display("[TB] FAIL sorted_pop%0d: got pv=%b data=%h required pv=1 data=%h",
                 i, bus.pop_valid, bus.pop_data, mk(wk[i], wi[i]));
      end
    end
    checks++;
    if (empty !== 1'b1 || last_pkt_info !== mk(9, 3)) begin
      failures++;
      $display("[TB] FAIL sorted_final: got empty=%b last=%h required empty=1 last=%h",
               empty, last_pkt_info, mk(9, 3));
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    cycle(1'b1, mk(7, 5), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.pop_valid !== 1'b0 || last_pkt_info !== mk(7, 5) || occupancy !== 5'd0
        || bus.pop_data !== mk(7, 5)) begin
      failures++;
      $display("[TB] FAIL pop_empty: got pv=%b last=%h occ=%0d pd=%h required pv=0 last=%h occ=0 pd=%h",
               bus.pop_valid, last_pkt_info, occupancy, bus.pop_data, mk(7, 5), mk(7, 5));
    end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, mk(k, k), 1'b0);
    cycle(1'b1, mk(3, 99), 1'b0);
    checks++;
    if (drop_cnt !== 16'd1 || occupancy !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_drop_status: got drop=%0d occ=%0d full=%b required drop=1 occ=16 full=1",
               drop_cnt, occupancy, full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1);
      checks++;
      if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp_pd) begin
        failures++;
        $display("[TB] FAIL full_drop_pop%0d: got pv=%b data=%h required pv=1 data=%h",
                 i, bus.pop_valid, bus.pop_data, exp_pd);
      end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int k = 10; k < 26; k++) cycle(1'b1, mk(k, k), 1'b0);
    cycle(1'b1, mk(1, 7), 1'b1);
    checks++;
    if (bus.pop_data !== mk(10, 10) || occupancy !== 5'd16 || drop_cnt !== 16'd0) begin
      failures++;
      $display("[TB] FAIL full_push_pop: got pd=%h occ=%0d drop=%0d required pd=%h occ=16 drop=0",
               bus.pop_data, occupancy, drop_cnt, mk(10, 10));
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== mk(1, 7)) begin
      failures++;
      $display("[TB] FAIL full_push_pop_next: got pv=%b pd=%h required pv=1 pd=%h",
               bus.pop_valid, bus.pop_data, mk(1, 7));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cycle(1'b1, mk(0, 0), 1'b0);
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, mk(c + 1, c), 1'b1);
      checks++;
      if (bus.pop_valid !== 1'b1 || key_of(bus.pop_data) != c || occupancy !== 5'd1) begin
        failures++;
        $display("[TB] FAIL back_to_back%0d: got pv=%b key=%0d occ=%0d required pv=1 key=%0d occ=1",
                 c, bus.pop_valid, key_of(bus.pop_data), occupancy, c);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < DEPTH; k++) cycle(1'b1, mk($urandom_range(0, 500), k), 1'b0);
    cycle(1'b1, mk(600, 1), 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (occupancy !== 5'd0 || bus.pop_valid !== 1'b0 || drop_cnt !== 16'd0 || empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_reset: got occ=%0d pv=%b drop=%0d empty=%b required 0/0/0/1",
               occupancy, bus.pop_valid, drop_cnt, empty);
    end
    do_reset();
    cycle(1'b1, mk(4, 4), 1'b0);
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.pop_valid !== 1'b1 || bus.pop_data !== mk(4, 4)) begin
      failures++;
      $display("[TB] FAIL async_reset_after: got pv=%b pd=%h required pv=1 pd=%h",
               bus.pop_valid, bus.pop_data, mk(4, 4));
    end
  endtask

  task automatic test_random();
    logic          pv;
    logic          pr;
    logic [DW-1:0] pd;
    do_reset();
    for (int n = 0; n < 500; n++) begin
      pv     = ($urandom_range(0, 99) < 65);
      pr     = ($urandom_range(0, 99) < 45);
      pd     = mk($urandom_range(0, 7), $urandom_range(0, 4095));
      pd[31] = 1'($urandom_range(0, 1));
      cycle(pv, pd, pr);
      checks++;
      if ({bus.pop_valid, bus.pop_data, last_pkt_info, occupancy, full, empty, drop_cnt}
          !== {exp_pv, exp_pd, exp_last, 5'(mq.size()), mq.size() == DEPTH, mq.size() == 0, 16'(exp_drop)}) begin
        failures++;
        $display("[TB] FAIL random%0d: got pv=%b pd=%h last=%h occ=%0d full=%b empty=%b drop=%0d required pv=%b pd=%h last=%h occ=%0d drop=%0d",
                 n, bus.pop_valid, bus.pop_data, last_pkt_info, occupancy, full, empty, drop_cnt,
                 exp_pv, exp_pd, exp_last, mq.size(), exp_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sorted_order();
    test_pop_empty();
    test_full_drop();
    test_full_push_pop();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pifo_rank_queue.md
Name: pifo_rank_queue

Overview:
- Sorted push-in-first-out queue on clk_dp, directly downstream of the DRR rank-calculation stage.
- Consumes each 32-bit rank tuple it produces, stores entries in ascending rank-key order, and pops the smallest key on scheduler request.
- Registers the last popped tuple as last_pkt_info. This feeds back to the rank stage's last_pkt_info input for this port.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 2.
- DATA_WIDTH, 32, stored tuple width (matches the rank stage's RESULT_WIDTH).
- KEY_LSB, 12, LSB of the sort key inside the tuple (above PIFO info).
- KEY_WIDTH, 19, sort key width: {id[7:0], round[10:0]} region of the tuple.
- CNT_WIDTH, 16, drop counter width.

Ports:
- clk_dp  in  1  datapath clock
- rst  in  1  asynchronous active-high reset
- push_valid  in  1  tuple valid from the rank stage
- push_data  in  DATA_WIDTH  rank tuple
- pop_req  in  1  scheduler dequeue request (single-cycle pulse per pop)
- pop_valid  out  1  pop result valid
- pop_data  out  DATA_WIDTH  popped tuple
- last_pkt_info  out  DATA_WIDTH  last successfully popped tuple, held
- occupancy  out  $clog2(DEPTH)+1  entries stored
- full  out  1  occupancy==DEPTH
- empty  out  1  occupancy==0
- drop_cnt  out  CNT_WIDTH  saturating count of rejected pushes

Behaviour:
- Reset (async, rst=1):
  - All entries invalid; occupancy=0, empty=1, full=0.
  - pop_valid=0, pop_data=0, last_pkt_info=0, drop_cnt=0.
  - A reset asserted mid-operation discards all contents immediately.
- Storage: shift-register array, slot 0 = head (smallest key). Per-slot valid bits are contiguous from slot 0.
- Key:
  - key = data[KEY_LSB+KEY_WIDTH-1:KEY_LSB], compared as an unsigned number.
  - No wrap-around compensation; round wrap is the rank stage's responsibility.
- Push insert position:
  - Insert position = number of valid entries with key <= new key, i.e. FIFO order among equal keys.
  - Entries at and above that position shift up one slot in the same cycle.
  - A pushed entry is visible at the head on the next cycle.
- Pop:
  - pop_req with empty=0: head removed and remaining entries shift down one slot.
  - The next cycle: pop_valid=1, pop_data=old head, last_pkt_info=old head.
  - pop_req with empty=1: ignored; pop_valid=0 next cycle and last_pkt_info unchanged.
- pop_valid: high exactly one cycle per successful pop. pop_data holds its value when pop_valid=0.
- Simultaneous push and pop, not empty:
  - The head is popped, then the new tuple is inserted into the remaining entries.
  - The insert position is computed against slots 1..occ-1.
  - occupancy is unchanged.
- Simultaneous push and pop when empty: the pop is ignored and the push is accepted; there is no same-cycle bypass.
- Push when full with no pop: the tuple is rejected and drop_cnt increments, saturating at all-ones.
- Push when full with simultaneous pop: accepted; no drop.
- Status timing: occupancy, full and empty are registered and reflect the state after the cycle's operations.
- Throughput: one push and one pop per cycle, sustained.

Optional Feature:
- Macro: PIFO_TAIL_EVICT_EN.
- With the macro defined, on a push when full with no pop:
  - If the new key < tail key (slot DEPTH-1), the tail entry is evicted and the new tuple is inserted in order.
  - drop_cnt increments (it counts evictions).
  - If the new key >= tail key, the new tuple is dropped as in the base behaviour.
- Without the macro: the new tuple is always dropped when full with no pop.

Test Plan:
- Sorted insert and pop order:
  - Stimulus: push keys 5, 2, 9, 2 (PIFO info 1, 2, 3, 4), then pop 4 times.
  - Required: pop_data keys 2(info 2), 2(info 4), 5, 9; empty=1 after the last pop; last_pkt_info = key 9 tuple.
- Pop on empty:
  - Stimulus: pop_req when occupancy=0.
  - Required: pop_valid stays 0; last_pkt_info unchanged; occupancy 0.
- Full drop:
  - Stimulus: fill 16 entries with keys 0..15, then push key 3.
  - Required: drop_cnt=1; occupancy=16; subsequent pops return 0..15. With PIFO_TAIL_EVICT_EN: pops return 0,1,2,3,3,4..14, and key 15 is lost.
- Simultaneous push/pop when full:
  - Stimulus: 16 entries with keys 10..25; push key 1 with pop_req.
  - Required: pop_data key 10; occupancy 16; next pop returns key 1; drop_cnt 0.
- Back-to-back throughput:
  - Stimulus: 20 cycles of push (key = cycle number) plus pop every cycle, starting from 1 entry with key 0.
  - Required: pop_valid high all 20 cycles; keys out in ascending order 0..19.
- Async reset mid-stream:
  - Stimulus: assert rst between clock edges with 7 entries stored.
  - Required: occupancy=0, pop_valid=0, drop_cnt=0 immediately, before the next edge; the first push after release pops correctly.
